// File: rtl/mem_stage_pkg.sv
// Shared widths, exception bit indices and the EX->MEM bus layout for the MEM stage.
`ifndef MEM_STAGE_DEFINES
`define MEM_STAGE_DEFINES
`define EX_TO_MEM_WD 167
`define MEM_TO_WB_WD 70
`define MEM_TO_RF_WD 38
`define MEM_EXC_MASK 16'hFFFC
`define EXC_OV 6
`define EXC_ADEL 7
`define EXC_ADES 8
`define EXC_PCADDR 9
`endif

package mem_stage_pkg;

  // mem_op one-hot bit positions, decoded as {lb, lbu, lh, lhu, lw, sb, sh, sw}
  localparam int OP_LB  = 7;
  localparam int OP_LBU = 6;
  localparam int OP_LH  = 5;
  localparam int OP_LHU = 4;
  localparam int OP_LW  = 3;

  typedef struct packed {
    logic [15:0] excepttype;
    logic [7:0]  mem_op;
    logic        hi_we;
    logic [31:0] hi;
    logic        lo_we;
    logic [31:0] lo;
    logic [31:0] ex_pc;
    logic        data_ram_en;
    logic        data_ram_wen;
    logic [3:0]  data_ram_sel;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects and extends the loaded byte/half/word from SRAM read data using the low address bits.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        unused_store_bits;

  assign unused_store_bits = ^mem_op[2:0];

  always_comb begin
    case (addr)
      2'd0:    byte_val = rdata[7:0];
      2'd1:    byte_val = rdata[15:8];
      2'd2:    byte_val = rdata[23:16];
      default: byte_val = rdata[31:24];
    endcase
    half_val = addr[1] ? rdata[31:16] : rdata[15:0];
    data = '0;
    if (mem_op[OP_LB])       data = ext8(byte_val, 1'b1);
    else if (mem_op[OP_LBU]) data = ext8(byte_val, 1'b0);
    else if (mem_op[OP_LH])  data = ext16(half_val, 1'b1);
    else if (mem_op[OP_LHU]) data = ext16(half_val, 1'b0);
    else if (mem_op[OP_LW])  data = rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: stage register, load data return, exception report and HI/LO commit.
// Optional MEM_HILO_FWD_EN shows a committing HI/LO value on hi_o/lo_o in its commit cycle.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     stall_ex,
  input  logic                     stall_mem,
  input  logic [`EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]              data_sram_rdata,
  output logic [`MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [`MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic [31:0]              hi_o,
  output logic [31:0]              lo_o,
  output logic                     except_valid,
  output logic [15:0]              except_type,
  output logic [31:0]              except_pc,
  output logic [31:0]              bad_vaddr
);

  ex_to_mem_t  stage_q;
  logic        valid_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        exc;
  logic        hilo_commit;
  logic        rf_we_out;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        unused_bus_bits;

  // A stall_ex bubble clears the whole register so downstream sees a clean nop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else if (stall_mem) begin
      valid_q <= valid_q;
      stage_q <= stage_q;
    end else if (stall_ex) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      valid_q <= 1'b1;
      stage_q <= ex_to_mem_bus;
    end
  end

  assign exc         = valid_q & (|(stage_q.excepttype & `MEM_EXC_MASK));
  assign hilo_commit = valid_q & ~exc & ~stall_mem & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_commit) begin
      if (stage_q.hi_we) hi_q <= stage_q.hi;
      if (stage_q.lo_we) lo_q <= stage_q.lo;
    end
  end

`ifdef MEM_HILO_FWD_EN
  assign hi_o = (hilo_commit && stage_q.hi_we) ? stage_q.hi : hi_q;
  assign lo_o = (hilo_commit && stage_q.lo_we) ? stage_q.lo : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

  mem_load_align u_load_align (
    .mem_op (stage_q.mem_op),
    .addr   (stage_q.ex_result[1:0]),
    .rdata  (data_sram_rdata),
    .data   (load_data)
  );

  assign rf_wdata  = stage_q.sel_rf_res ? load_data : stage_q.ex_result;
  assign rf_we_out = stage_q.rf_we & valid_q & ~exc;

  assign mem_to_rf_bus = {rf_we_out, stage_q.rf_waddr, rf_wdata};
  assign mem_to_wb_bus = {stage_q.ex_pc, rf_we_out, stage_q.rf_waddr, rf_wdata};

  assign except_valid = exc;
  assign except_type  = stage_q.excepttype;
  assign except_pc    = stage_q.ex_pc;
  assign bad_vaddr    = (stage_q.excepttype[`EXC_ADEL] || stage_q.excepttype[`EXC_ADES])
                        ? stage_q.ex_result : stage_q.ex_pc;

  // Store strobes are consumed by the SRAM interface in EX, not here.
  assign unused_bus_bits = ^{stage_q.data_ram_en, stage_q.data_ram_wen, stage_q.data_ram_sel};

endmodule
